// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit for the EX stage. It uses a radix-2
// shift-add multiplier and a restoring divider. Both share one 64-bit
// accumulator. One operation is in flight at a time. A normal operation takes
// 32 CALC cycles and 1 FIN cycle, and `o_done` follows one cycle later.
//
// Parameters
//   EARLY_OUT  1: divide-by-zero and signed-overflow divides finish in 1 cycle
//
// Ports
//   i_clk      system clock, rising edge
//   i_reset_n  synchronous active-low reset
//   i_start    issue request, sampled only in IDLE
//   i_funct3   RV32M op (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   i_a, i_b   forwarded rs1 / rs2 operands
//   i_flush    abort the in-flight operation
//   o_busy     registered, high while an operation is in flight
//   o_done     registered one-cycle pulse when o_result is valid
//   o_result   registered result, holds until the next completion
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t      r_state, w_next_state;
    logic [2:0]  r_funct3;
    logic [31:0] r_op_b;      // multiplicand or divisor magnitude
    logic [63:0] r_acc;       // {hi, lo} product, or {rem, quo} for divides
    logic        r_neg;       // final result needs two's-complement negate
    logic [5:0]  r_count;
    logic        r_busy, r_done;
    logic [31:0] r_result;

    // ---------------- issue-time operand preparation ----------------
    logic        w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic        w_b_zero, w_overflow, w_early, w_accept, w_neg;
    logic [31:0] w_a_mag, w_b_mag, w_early_result;

    assign w_is_div = i_funct3[2];

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        unique case (i_funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            3'b010:                         w_a_signed = 1'b1;
            default:                        ;
        endcase
    end

    assign w_a_neg    = w_a_signed & i_a[31];
    assign w_b_neg    = w_b_signed & i_b[31];
    assign w_a_mag    = w_a_neg ? 32'd0 - i_a : i_a;
    assign w_b_mag    = w_b_neg ? 32'd0 - i_b : i_b;
    assign w_b_zero   = (i_b == 32'd0);
    assign w_overflow = w_is_div & ~i_funct3[0] & (i_a == 32'h8000_0000) & (i_b == 32'hFFFF_FFFF);
    assign w_early    = EARLY_OUT & w_is_div & (w_b_zero | w_overflow);
    assign w_accept   = (r_state == S_IDLE) & i_start & ~i_flush;

    // A quotient's sign is forced positive on x/0 so the all-ones magnitude
    // from the datapath already equals the required 0xFFFFFFFF.
    always_comb begin
        w_neg = w_a_neg ^ w_b_neg;
        if (w_is_div) begin
            if (i_funct3[1]) w_neg = w_a_neg;
            else             w_neg = (w_a_neg ^ w_b_neg) & ~w_b_zero;
        end
    end

    always_comb begin
        if (!i_funct3[1]) w_early_result = w_b_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
        else              w_early_result = w_b_zero ? i_a : 32'd0;
    end

    // ---------------- one iteration of each datapath ----------------
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_step;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic        w_take;
    logic [63:0] w_div_step;

    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_op_b} : 33'd0);
    assign w_mul_step = {w_mul_sum, r_acc[31:1]};

    // The shifted remainder can reach 33 bits. If its top bit is set, it
    // certainly exceeds the divisor. Otherwise the 33-bit subtract's borrow
    // decides. The low 32 bits of the difference are exact in both cases.
    assign w_rem_sh   = r_acc[63:31];
    assign w_diff     = {1'b0, w_rem_sh[31:0]} - {1'b0, r_op_b};
    assign w_take     = w_rem_sh[32] | ~w_diff[32];
    assign w_div_step = w_take ? {w_diff[31:0], r_acc[30:0], 1'b1}
                               : {w_rem_sh[31:0], r_acc[30:0], 1'b0};

    // ---------------- sign correction and output select ----------------
    logic [63:0] w_prod;
    logic [31:0] w_quo, w_rem, w_fin_result;

    assign w_prod = r_neg ? 64'd0 - r_acc : r_acc;
    assign w_quo  = r_neg ? 32'd0 - r_acc[31:0] : r_acc[31:0];
    assign w_rem  = r_neg ? 32'd0 - r_acc[63:32] : r_acc[63:32];

    always_comb begin
        unique case (r_funct3)
            3'b000:                 w_fin_result = w_prod[31:0];
            3'b001, 3'b010, 3'b011: w_fin_result = w_prod[63:32];
            3'b100, 3'b101:         w_fin_result = w_quo;
            default:                w_fin_result = w_rem;
        endcase
    end

    // ---------------- control FSM ----------------
    logic        w_load_result;
    logic [31:0] w_result_next;

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        w_load_result = 1'b0;
        w_result_next = w_fin_result;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_early) begin
                        w_load_result = 1'b1;
                        w_result_next = w_early_result;
                    end else begin
                        w_next_state = S_CALC;
                    end
                end
            end
            S_CALC: if (r_count == 6'd31) w_next_state = S_FIN;
            S_FIN: begin
                w_load_result = 1'b1;
                w_next_state  = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        if (i_flush) begin
            w_next_state  = S_IDLE;
            w_load_result = 1'b0;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_funct3 <= 3'd0;
            r_op_b   <= 32'd0;
            r_acc    <= 64'd0;
            r_neg    <= 1'b0;
            r_count  <= 6'd0;
        end else if (w_accept && !w_early) begin
            r_funct3 <= i_funct3;
            r_neg    <= w_neg;
            r_count  <= 6'd0;
            if (w_is_div) begin
                r_acc  <= {32'd0, w_a_mag};
                r_op_b <= w_b_mag;
            end else begin
                r_acc  <= {32'd0, w_b_mag};
                r_op_b <= w_a_mag;
            end
        end else if (r_state == S_CALC) begin
            r_acc   <= r_funct3[2] ? w_div_step : w_mul_step;
            r_count <= r_count + 6'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 32'd0;
        end else begin
            r_busy <= (w_next_state != S_IDLE);
            r_done <= w_load_result;
            if (w_load_result) r_result <= w_result_next;
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench. It uses two instances: u_dut_e has early-out enabled
// and u_dut_n does not. Expected results come from a plain 64-bit arithmetic
// model of the RV32M rules.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam bit SEL_E = 1'b0;
    localparam bit SEL_N = 1'b1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_e, start_n, flush;
    logic [2:0]  funct3;
    logic [31:0] a_in, b_in;
    logic        busy_e, done_e, busy_n, done_n;
    logic [31:0] result_e, result_n;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_e = 32'd0;
    logic [31:0] last_n = 32'd0;

    always #5 clk = ~clk;

    muldiv_unit #(.EARLY_OUT(1'b1)) u_dut_e (
        .i_clk(clk), .i_reset_n(reset_n), .i_start(start_e), .i_funct3(funct3),
        .i_a(a_in), .i_b(b_in), .i_flush(flush),
        .o_busy(busy_e), .o_done(done_e), .o_result(result_e)
    );

    muldiv_unit #(.EARLY_OUT(1'b0)) u_dut_n (
        .i_clk(clk), .i_reset_n(reset_n), .i_start(start_n), .i_funct3(funct3),
        .i_a(a_in), .i_b(b_in), .i_flush(flush),
        .o_busy(busy_n), .o_done(done_n), .o_result(result_n)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'd0, b});
        logic [63:0] p;
        longint      q;
        logic [63:0] qq;
        model = 32'd0;
        case (f)
            3'b000: begin p = sa * sb; model = p[31:0]; end
            3'b001: begin p = sa * sb; model = p[63:32]; end
            3'b010: begin p = sa * ub; model = p[63:32]; end
            3'b011: begin p = {32'd0, a} * {32'd0, b}; model = p[63:32]; end
            3'b100: begin
                if (b == 0) model = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'h8000_0000;
                else begin q = sa / sb; qq = q; model = qq[31:0]; end
            end
            3'b101: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) model = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'd0;
                else begin q = sa % sb; qq = q; model = qq[31:0]; end
            end
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) start_n = v;
        else     start_e = v;
    endtask

    // Called right after the negedge where start was raised (cycle 0). Returns
    // the cycle number of the done pulse and the number of cycles where busy
    // disagreed with "busy until done, idle on done".
    task automatic wait_done(input bit sel, input bit spurious, output int lat, output int busy_bad);
        bit got = 0;
        logic d, bz;
        lat = 0;
        busy_bad = 0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            set_start(sel, 1'b0);
            if (spurious && lat == 5) begin
                set_start(sel, 1'b1);
                funct3 = 3'($urandom_range(0, 7));
                a_in   = $urandom;
                b_in   = $urandom;
            end
            d  = sel ? done_n : done_e;
            bz = sel ? busy_n : busy_e;
            if (d) begin
                got = 1;
                if (bz) busy_bad++;
            end else if (!bz) begin
                busy_bad++;
            end
        end
    endtask

    task automatic do_op(input bit sel, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit spurious);
        logic [31:0] exp = model(f, a, b);
        int          exp_lat = (!sel && is_special(f, a, b)) ? 1 : 34;
        int          lat, busy_bad;
        @(negedge clk);
        funct3 = f;
        a_in   = a;
        b_in   = b;
        set_start(sel, 1'b1);
        wait_done(sel, spurious, lat, busy_bad);
        check($sformatf("latency f=%0d a=%h b=%h", f, a, b), lat, exp_lat);
        check($sformatf("result f=%0d a=%h b=%h", f, a, b), sel ? result_n : result_e, exp);
        check("busy_profile", busy_bad, 0);
        @(negedge clk);
        check("done_single_pulse", sel ? done_n : done_e, 1'b0);
        check("idle_busy", sel ? busy_n : busy_e, 1'b0);
        check("result_hold", sel ? result_n : result_e, exp);
        if (sel) last_n = exp;
        else     last_e = exp;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, busy_bad, bad;
        reset_n = 1'b0;
        start_e = 1'b0;
        start_n = 1'b0;
        flush   = 1'b0;
        funct3  = 3'd0;
        a_in    = 32'd0;
        b_in    = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy_e", busy_e, 1'b0);
        check("reset_done_e", done_e, 1'b0);
        check("reset_result_e", result_e, 32'd0);
        check("reset_result_n", result_n, 32'd0);
        reset_n = 1'b1;

        // Directed cases.
        do_op(SEL_E, 3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
        check("mul_7_m3", result_e, 32'hFFFF_FFEB);
        do_op(SEL_E, 3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op(SEL_E, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(SEL_E, 3'b010, 32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op(SEL_E, 3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(SEL_E, 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(SEL_E, 3'b101, 32'd100, 32'd7, 1'b0);
        do_op(SEL_E, 3'b111, 32'd100, 32'd7, 1'b0);
        for (int s = 0; s < 2; s++) begin
            do_op(s[0], 3'b101, 32'd5, 32'd0, 1'b0);
            do_op(s[0], 3'b110, 32'd5, 32'd0, 1'b0);
            do_op(s[0], 3'b100, 32'hFFFF_FFF9, 32'd0, 1'b0);
            do_op(s[0], 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
            do_op(s[0], 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        end
        do_op(SEL_N, 3'b100, 32'd1000, 32'd7, 1'b1);

        // Flush: DIV in cycle 0, ignored start in cycle 5, flush in cycle 10.
        bad = 0;
        @(negedge clk);
        funct3 = 3'b100; a_in = 32'd1000; b_in = 32'd7; start_e = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start_e = 1'b0;
            if (c == 5) begin start_e = 1'b1; funct3 = 3'b000; a_in = 32'd3; b_in = 32'd4; end
            if (c == 10) flush = 1'b1;
            if (done_e || !busy_e) bad++;
        end
        @(negedge clk);
        flush = 1'b0;
        check("flush_pre_profile", bad, 0);
        check("flush_busy", busy_e, 1'b0);
        check("flush_done", done_e, 1'b0);
        check("flush_result_kept", result_e, last_e);
        funct3 = 3'b011; a_in = 32'hDEAD_BEEF; b_in = 32'h1234_5678; start_e = 1'b1;
        wait_done(SEL_E, 1'b0, lat, busy_bad);
        check("flush_mulhu_cycle", 11 + lat, 45);
        check("flush_mulhu_result", result_e, model(3'b011, 32'hDEAD_BEEF, 32'h1234_5678));
        check("flush_mulhu_busy", busy_bad, 0);

        // Reset in cycle 20 of a DIV.
        @(negedge clk);
        funct3 = 3'b100; a_in = 32'd12345; b_in = 32'd17; start_e = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start_e = 1'b0;
            if (c == 20) reset_n = 1'b0;
        end
        @(negedge clk);
        check("rst_busy", busy_e, 1'b0);
        check("rst_done", done_e, 1'b0);
        check("rst_result_e", result_e, 32'd0);
        check("rst_result_n", result_n, 32'd0);
        reset_n = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (done_e || done_n || busy_e) bad++;
        end
        check("rst_no_done", bad, 0);
        last_e = 32'd0;
        last_n = 32'd0;

        // Randomized operations against the model.
        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
                  1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting in the EX stage beside the ALU. It consumes the same forwarded rs1/rs2 operands that feed the ALU and returns a 32-bit result to the EX/MEM result mux. While it computes, `busy` tells the hazard-detection logic to hold PC, IF/ID and ID/EX. It executes one instruction at a time, using a radix-2 shift-add multiplier and a restoring divider.

## Interface
- `EARLY_OUT`, 1, when 1, divide-by-zero and signed-overflow divides complete in 1 cycle; when 0, they take the full iterative latency (results are identical either way).
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  issue request; sampled only in IDLE.
- `funct3`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  32  rs1 operand, after forwarding.
- `b`  in  32  rs2 operand, after forwarding.
- `flush`  in  1  abort the in-flight operation (branch/jump flush).
- `busy`  out  1  registered; high while an operation is in flight.
- `done`  out  1  registered; one-cycle pulse when `result` is valid.
- `result`  out  32  registered result; holds until the next completion.

## Operation
- States: IDLE, CALC, FIN.
- IDLE + `start`:
  - Latch `funct3`.
  - Latch operand magnitudes: signed ops take |a|, |b|; MULHSU takes |a| and raw b.
  - Latch the result sign.
  - Clear the 6-bit iteration count.
  - Go to CALC.
- Early-out case (`EARLY_OUT`=1 and divide with b==0, or DIV/REM with a=0x80000000, b=0xFFFFFFFF): load `result`, pulse `done`, stay IDLE.
- CALC, multiply: each cycle, if the multiplier LSB is 1, add the multiplicand into the upper half of a 64-bit accumulator; then shift right 1.
- CALC, divide: each cycle, shift {rem,quo} left 1; if rem ≥ divisor, subtract the divisor and set quo[0]. Use a 33-bit subtract; the borrow decides.
- Iteration count: 32 iterations, then go to FIN.
- FIN:
  - Apply sign correction (two's-complement negate).
  - Select the output: MUL takes low 32 bits; MULH/MULHSU/MULHU take high 32 bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Register `result`, pulse `done`, go to IDLE.
- Sign rules:
  - Product is negative when the operand signs differ (MULHSU uses a's sign only).
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Special results (RISC-V spec):
  - x/0: quotient 0xFFFFFFFF, remainder a.
  - DIV overflow: quotient 0x80000000, remainder 0.
  - When `EARLY_OUT`=0 the datapath must produce these same values.
- `start` while not IDLE: ignored.
- `flush`: next edge goes to IDLE with `busy`=0; no `done`; `result` unchanged. A `start` in the same cycle as `flush`, taken from IDLE, is also dropped.
- Priority: `reset_n` > `flush` > `start`.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, internal accumulators 0.
- Numbering: `start` sampled at the end of cycle 0.
- Normal op:
  - `busy`=1 in cycles 1–33 (CALC 1–32, FIN 33).
  - `done`=1 and `result` valid in cycle 34, with `busy`=0 in that cycle.
  - A new `start` is accepted in cycle 34.
- Early-out: `done`=1 in cycle 1, `busy` never asserted.
- The pipeline controller stalls on `start`|`busy` in EX; the unit does not gate its own `start`.
- `flush` in cycle k while busy: `busy`=0 in cycle k+1; `start` is accepted in cycle k+1.
- `reset_n` low in cycle k: all outputs at reset values in cycle k+1, regardless of state.

## Test plan
- **MUL:** a=7, b=0xFFFFFFFD, start in cycle 0 -> `busy` cycles 1–33; `done` only in cycle 34; `result`=0xFFFFFFEB.
- **High-half multiplies:**
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- **Divide/remainder:**
  - DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
- **Specials:**
  - DIVU 5/0 -> 0xFFFFFFFF, `done` in cycle 1, `busy` stays 0.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
  - Repeat with `EARLY_OUT`=0 -> same values, `done` in cycle 34.
- **Flush and ignored start:**
  - DIV started in cycle 0; `start` with new operands in cycle 5 is ignored.
  - `flush` in cycle 10 -> `busy`=0 in cycle 11; no `done`; `result` keeps its prior value.
  - Fresh MULHU started in cycle 11 -> `done` in cycle 45.
- **Reset mid-op:** `reset_n` low in cycle 20 of a DIV -> cycle 21 has `busy`=0, `done`=0, `result`=0; no `done` follows after `reset_n` returns high.
